mem_access: RTL
===============

Name: mem_access

Overview:
Memory-access pipeline stage. It is the consumer of the execute stage's load/store outputs (l*/s* strobes, effective address, store data, writeback triple).
- Issues one data-bus transaction per load/store via a req/gnt/rvalid handshake.
- Stalls upstream with hold_mem while the transaction is in flight.
- Formats load data (lane select, sign/zero extension).
- Registers the writeback triple toward the register-file write stage.

Parameters:
BUS_TIMEOUT, 255, cycles allowed in REQ or RESP before the access is aborted with bus_err_mem (counter width 8 bits minimum).

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
lb_exe, lh_exe, lbu_exe, lhu_exe, lw_exe  input  1 each  load type strobes (at most one high)
sb_exe, sh_exe, sw_exe  input  1 each  store type strobes
mem_addr_exe  input  32  effective byte address
reg_rdata2_exe  input  32  store data (rs2)
reg_wen_exe  input  1  writeback enable from execute
reg_waddr_exe  input  5  writeback register
reg_wdata_exe  input  32  ALU/CSR/link result
hold_mem  output  1  stall request to pipeline control (drives hold_ctl upstream)
dbus_req  output  1  bus request
dbus_we  output  1  1 = write
dbus_addr  output  32  word-aligned address {addr[31:2],2'b00}
dbus_be  output  4  byte enables
dbus_wdata  output  32  lane-replicated store data
dbus_gnt  input  1  request accepted
dbus_rvalid  input  1  read data valid
dbus_rdata  input  32  read data
reg_wen_mem  output  1  registered writeback enable
reg_waddr_mem  output  5  registered writeback address
reg_wdata_mem  output  32  registered writeback data
bus_err_mem  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_b=0, async): state IDLE, timeout counter 0, all registered outputs 0.
  - dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, reg_wen_mem, reg_waddr_mem, reg_wdata_mem, bus_err_mem all 0.
  - Reset mid-transaction: dbus_req drops immediately. Any pending response is discarded.
- mem_op = OR of all eight strobes.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - hold_mem = mem_op (combinational).
  - If mem_op: latch type, addr, be, wdata, we, waddr; go to REQ. Bubble written (reg_wen_mem<=0).
  - Else: pass-through with 1-cycle latency: reg_wen_mem <= reg_wen_exe & (reg_waddr_exe!=0); reg_waddr_mem <= reg_waddr_exe; reg_wdata_mem <= reg_wdata_exe.
- REQ:
  - dbus_req=1. Bus outputs come from latched values and are stable until gnt.
  - On gnt: store -> DONE; load -> RESP.
  - rvalid is ignored in REQ.
- RESP:
  - dbus_req=0.
  - On rvalid: capture the formatted load result; go to DONE.
- REQ and RESP: hold_mem=1; reg_wen_mem <= 0.
- DONE:
  - hold_mem=0, so execute advances at this edge. The strobes still visible this cycle are the completed op and are not re-issued.
  - Load: reg_wen_mem <= (waddr!=0), reg_waddr_mem <= latched waddr, reg_wdata_mem <= formatted data.
  - Store: reg_wen_mem <= 0.
  - Next state IDLE. Back-to-back ops cost one IDLE cycle.
- Timeout:
  - Counter clears on entering REQ and on the REQ->RESP transition. It increments each cycle in REQ/RESP.
  - On reaching BUS_TIMEOUT: dbus_req<=0, bus_err_mem pulses one cycle, reg_wen_mem <= 0, state goes to DONE.
  - A late rvalid is ignored in IDLE/DONE.
- Byte enables (a = addr[1:0]):
  - sb/lb/lbu: 4'b0001<<a.
  - sh/lh/lhu: a[1] ? 1100 : 0011.
  - sw/lw: 1111.
- wdata: sb {4{rs2[7:0]}}; sh {2{rs2[15:0]}}; sw rs2.
- Load format:
  - Byte = rdata[8a+7:8a]; half = a[1] ? rdata[31:16] : rdata[15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw full word.
- Alignment is not checked; misalignment is flagged upstream. Half accesses use a[1] only.

Test Plan:
- Non-mem op (reg_wen_exe=1, waddr=5, wdata=0x1234): next cycle reg_wen_mem=1, waddr_mem=5, wdata_mem=0x1234, hold_mem=0; waddr=0 gives reg_wen_mem=0.
- sb addr=0x1003, rs2=0xAB, gnt after 2 cycles: dbus_addr=0x1000, be=1000, wdata=0xABABABAB, we=1; hold_mem high through REQ; DONE gives reg_wen_mem=0.
- lb addr=0x2002, rdata=0x00800000, rvalid 3 cycles after gnt: reg_wdata_mem=0xFFFFFF80; same with lbu gives 0x00000080; lhu addr=0x2002, rdata=0x8001FFFF gives 0x00008001.
- Back-to-back lw then sw: exactly one req per op, no re-issue in DONE, second req one IDLE cycle after first DONE.
- gnt never asserted, BUS_TIMEOUT=4: bus_err_mem pulses once, dbus_req low, reg_wen_mem=0, FSM returns to IDLE.
- rst_b low during RESP: dbus_req/hold_mem/outputs 0 immediately; rvalid after release is ignored.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory stage issuing one req/gnt/rvalid bus transaction per load/store.
// Formats load data and registers the writeback triple.
module mem_access #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        lb_exe,
  input  logic        lh_exe,
  input  logic        lbu_exe,
  input  logic        lhu_exe,
  input  logic        lw_exe,
  input  logic        sb_exe,
  input  logic        sh_exe,
  input  logic        sw_exe,
  input  logic [31:0] mem_addr_exe,
  input  logic [31:0] reg_rdata2_exe,
  input  logic        reg_wen_exe,
  input  logic [4:0]  reg_waddr_exe,
  input  logic [31:0] reg_wdata_exe,
  output logic        hold_mem,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        reg_wen_mem,
  output logic [4:0]  reg_waddr_mem,
  output logic [31:0] reg_wdata_mem,
  output logic        bus_err_mem
);
  localparam int CW = BUS_TIMEOUT > 255 ? $clog2(BUS_TIMEOUT + 1) : 8;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic we, sgn;
  logic [1:0] sz, a, ea;
  logic [4:0] waddr;
  logic [31:0] ldata, fmt;
  logic [7:0] rb;
  logic [15:0] rh;
  logic mem_op, is_b, is_h, is_st, timeout;
  assign mem_op = lb_exe | lh_exe | lbu_exe | lhu_exe | lw_exe | sb_exe | sh_exe | sw_exe;
  assign is_b = lb_exe | lbu_exe | sb_exe;
  assign is_h = lh_exe | lhu_exe | sh_exe;
  assign is_st = sb_exe | sh_exe | sw_exe;
  assign ea = mem_addr_exe[1:0];
  assign timeout = cnt == CW'(BUS_TIMEOUT - 1);
  assign hold_mem = state == IDLE ? mem_op : state != DONE;
  // sz: 0 byte, 1 half, 2 word
  assign rb = dbus_rdata[{a, 3'b000} +: 8];
  assign rh = a[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
  assign fmt = sz == 2'd0 ? {{24{sgn & rb[7]}}, rb} :
               sz == 2'd1 ? {{16{sgn & rh[15]}}, rh} : dbus_rdata;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt <= '0;
      we <= 1'b0;
      sgn <= 1'b0;
      sz <= 2'd0;
      a <= 2'd0;
      waddr <= 5'd0;
      ldata <= 32'd0;
      dbus_req <= 1'b0;
      dbus_we <= 1'b0;
      dbus_addr <= 32'd0;
      dbus_be <= 4'd0;
      dbus_wdata <= 32'd0;
      reg_wen_mem <= 1'b0;
      reg_waddr_mem <= 5'd0;
      reg_wdata_mem <= 32'd0;
      bus_err_mem <= 1'b0;
    end else begin
      bus_err_mem <= 1'b0;
      case (state)
        IDLE:
          if (mem_op) begin
            state <= REQ;
            cnt <= '0;
            dbus_req <= 1'b1;
            dbus_we <= is_st;
            we <= is_st;
            dbus_addr <= {mem_addr_exe[31:2], 2'b00};
            dbus_be <= is_b ? 4'b0001 << ea : is_h ? (ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            dbus_wdata <= is_b ? {4{reg_rdata2_exe[7:0]}} :
                          is_h ? {2{reg_rdata2_exe[15:0]}} : reg_rdata2_exe;
            sz <= is_b ? 2'd0 : is_h ? 2'd1 : 2'd2;
            sgn <= lb_exe | lh_exe;
            a <= ea;
            waddr <= reg_waddr_exe;
            reg_wen_mem <= 1'b0;
          end else begin
            reg_wen_mem <= reg_wen_exe & (reg_waddr_exe != 5'd0);
            reg_waddr_mem <= reg_waddr_exe;
            reg_wdata_mem <= reg_wdata_exe;
          end
        REQ: begin
          reg_wen_mem <= 1'b0;
          cnt <= dbus_gnt ? '0 : cnt + 1'b1;
          if (dbus_gnt) begin
            dbus_req <= 1'b0;
            state <= we ? DONE : RESP;
          end else if (timeout) begin
            dbus_req <= 1'b0;
            bus_err_mem <= 1'b1;
            state <= DONE;
          end
        end
        RESP: begin
          reg_wen_mem <= 1'b0;
          cnt <= cnt + 1'b1;
          if (dbus_rvalid) begin
            ldata <= fmt;
            state <= DONE;
          end else if (timeout) begin
            bus_err_mem <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // bus_err_mem is still high here when the access was aborted
          state <= IDLE;
          reg_wen_mem <= !we && !bus_err_mem && waddr != 5'd0;
          if (!we && !bus_err_mem) begin
            reg_waddr_mem <= waddr;
            reg_wdata_mem <= ldata;
          end
        end
      endcase
    end
  end
endmodule
